// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory bus arbiter: FSM states, owner ids, transfer direction.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state_t, OWN_CPU/OWN_DMA, RD/WR, max_int helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Owner ids double as the bit index of the request vector fed to arb2_alt.
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/arb2_alt.sv
// Two-way alternating-priority grant; a tie goes to whichever side was not granted last.
// Latency: grant is combinational from req; the last-grant flop updates on the enabled grant edge.
// Backpressure: none; a requester simply stays unserved until it is granted.
// Ports: clk, reset (sync, active-high), req[1:0] (bit0 CPU, bit1 DMA), en (grant may be taken),
//        grant[1:0] one-hot winner, next_last = owner id that last_grant takes when en and a req is up.
module arb2_alt
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant,
  output logic       next_last
);

  logic last_grant;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last_grant == OWN_DMA) ? 2'b01 : 2'b10;
    end
    next_last = last_grant;
    if (grant[1]) begin
      next_last = OWN_DMA;
    end else if (grant[0]) begin
      next_last = OWN_CPU;
    end
  end

  // Resetting to DMA makes the first tie after reset go to the CPU.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= OWN_DMA;
    end else if (en && (|req)) begin
      last_grant <= next_last;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the CPU controller and a DMA requester; sequences IDLE/SETUP/ACCESS/DONE.
// Latency: req in IDLE cycle t -> done at t+2+WAIT_STATES with mem_ready high; one IDLE gap between transfers.
// Backpressure: requests are level-held until done; mem_ready stretches ACCESS (BUS_TIMEOUT_EN bounds it).
// Ports: clk, reset (sync, active-high); cpu_req/rd_wr/addr/wdata -> cpu_rdata/cpu_done; same set for dma_*;
//        mem_cs/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready memory side; bus_busy (not IDLE); bus_err.
// Build option: define BUS_TIMEOUT_EN to abort an ACCESS after TIMEOUT_CYCLES cycles without mem_ready.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int WAIT_STATES    = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_rd_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              dma_req,
  input  logic              dma_rd_wr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              bus_busy,
  output logic              bus_err
);

  localparam int CNT_MAX = max_int(WAIT_STATES, TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] WS_LAST = CNT_W'(WAIT_STATES - 1);

  state_t           state;
  logic             owner;
  logic             rd_wr;
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  logic [1:0]       grant;
  logic             next_last;
  logic             ready_ok;
  logic             timeout;

  // Only an IDLE grant moves last_grant, so requests arriving mid-transfer just wait.
  arb2_alt u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       ({dma_req, cpu_req}),
    .en        (state == ST_IDLE),
    .grant     (grant),
    .next_last (next_last)
  );

  // mem_ready is honoured only once the minimum wait count has elapsed.
  assign ready_ok = (wait_cnt >= WS_LAST) && mem_ready;

`ifdef BUS_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  assign timeout = !ready_ok && (wait_cnt >= TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  assign bus_err = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      owner     <= OWN_CPU;
      rd_wr     <= RD;
      wait_cnt  <= '0;
      err_q     <= 1'b0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      cpu_done  <= 1'b0;
      dma_done  <= 1'b0;
      bus_busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            // next_last already names the winner of this grant.
            state     <= ST_SETUP;
            owner     <= next_last;
            rd_wr     <= (next_last == OWN_DMA) ? dma_rd_wr : cpu_rd_wr;
            mem_addr  <= (next_last == OWN_DMA) ? dma_addr  : cpu_addr;
            mem_wdata <= (next_last == OWN_DMA) ? dma_wdata : cpu_wdata;
            mem_cs    <= 1'b1;
            mem_we    <= 1'b0;
            bus_busy  <= 1'b1;
            wait_cnt  <= '0;
          end
        end
        ST_SETUP: begin
          state    <= ST_ACCESS;
          mem_we   <= (rd_wr == WR);
          wait_cnt <= '0;
        end
        ST_ACCESS: begin
          if (ready_ok || timeout) begin
            state  <= ST_DONE;
            mem_cs <= 1'b0;
            mem_we <= 1'b0;
            err_q  <= timeout;
            if (owner == OWN_DMA) begin
              dma_done <= 1'b1;
            end else begin
              cpu_done <= 1'b1;
            end
            // A timed-out read returns zero rather than whatever is floating on mem_rdata.
            if (rd_wr == RD) begin
              if (owner == OWN_DMA) begin
                dma_rdata <= timeout ? '0 : mem_rdata;
              end else begin
                cpu_rdata <= timeout ? '0 : mem_rdata;
              end
            end
          end else if (wait_cnt != CNT_SAT) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          cpu_done <= 1'b0;
          dma_done <= 1'b0;
          err_q    <= 1'b0;
          bus_busy <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset, CPU read, DMA write with wait states, tie alternation,
// early mem_ready, reset mid-transfer and the timeout option.
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_rd_wr, dma_req, dma_rd_wr;
  logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_done, dma_done, mem_cs, mem_we, mem_ready, bus_busy, bus_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_rd_wr(cpu_rd_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .dma_req(dma_req), .dma_rd_wr(dma_rd_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_done(dma_done),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_busy(bus_busy), .bus_err(bus_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_req = 0; cpu_rd_wr = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_rd_wr = 0; dma_addr = '0; dma_wdata = '0;
    mem_rdata = '0; mem_ready = 0;
    tick(); tick();
    n_cmp++; if (mem_cs !== 1'b0) begin n_bad++; $display("FAIL reset_cs got %b want 0", mem_cs); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b want 0", mem_we); end
    n_cmp++; if (bus_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus_busy); end
    n_cmp++; if ({cpu_done, dma_done, bus_err} !== 3'b000) begin n_bad++; $display("FAIL reset_done_err got %b want 000", {cpu_done, dma_done, bus_err}); end
    n_cmp++; if (cpu_rdata !== 16'h0 || dma_rdata !== 16'h0) begin n_bad++; $display("FAIL reset_rdata got %h/%h want 0000/0000", cpu_rdata, dma_rdata); end
    n_cmp++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin n_bad++; $display("FAIL reset_mem_bus got %h/%h want 0000/0000", mem_addr, mem_wdata); end
    reset = 1'b0;
    tick();
    n_cmp++; if (bus_busy !== 1'b0) begin n_bad++; $display("FAIL idle_no_req_busy got %b want 0", bus_busy); end
  endtask

  task automatic test_cpu_read();
    int cs_cnt = 0, we_cnt = 0, done_cnt = 0, done_at = 0, dma_cnt = 0, first_cs = 0;
    cpu_rd_wr = 1'b1; cpu_addr = 16'h0020; mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    cpu_req = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (mem_cs) begin cs_cnt++; if (first_cs == 0) first_cs = i; end
      if (mem_we) we_cnt++;
      if (dma_done) dma_cnt++;
      if (cpu_done) begin done_cnt++; done_at = i; cpu_req = 1'b0; end
    end
    n_cmp++; if (cs_cnt !== 3) begin n_bad++; $display("FAIL rd_cs_cycles got %0d want 3", cs_cnt); end
    n_cmp++; if (first_cs !== 1) begin n_bad++; $display("FAIL rd_cs_start got %0d want 1", first_cs); end
    n_cmp++; if (we_cnt !== 0) begin n_bad++; $display("FAIL rd_we_cycles got %0d want 0", we_cnt); end
    n_cmp++; if (done_at !== 4 || done_cnt !== 1) begin n_bad++; $display("FAIL rd_done got at %0d x%0d want at 4 x1", done_at, done_cnt); end
    n_cmp++; if (cpu_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL rd_data got %h want beef", cpu_rdata); end
    n_cmp++; if (mem_addr !== 16'h0020) begin n_bad++; $display("FAIL rd_addr got %h want 0020", mem_addr); end
    n_cmp++; if (dma_cnt !== 0) begin n_bad++; $display("FAIL rd_dma_done got %0d want 0", dma_cnt); end
  endtask

  task automatic test_dma_write_wait();
    int cs_cnt = 0, we_cnt = 0, first_we = 0, unstable = 0, dma_cnt = 0, done_at = 0, cpu_cnt = 0;
    logic busy7 = 1'b0, busy8 = 1'b1;
    dma_rd_wr = 1'b0; dma_addr = 16'h0100; dma_wdata = 16'h1234; mem_ready = 1'b0;
    dma_req = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (mem_cs) begin cs_cnt++; if (mem_addr !== 16'h0100 || mem_wdata !== 16'h1234) unstable++; end
      if (mem_we) begin we_cnt++; if (first_we == 0) first_we = i; end
      if (cpu_done) cpu_cnt++;
      if (i == 7) busy7 = bus_busy;
      if (i == 8) busy8 = bus_busy;
      if (dma_done) begin dma_cnt++; done_at = i; dma_req = 1'b0; mem_ready = 1'b0; end
      if (i == 6) mem_ready = 1'b1;
    end
    n_cmp++; if (cs_cnt !== 6) begin n_bad++; $display("FAIL wr_cs_cycles got %0d want 6", cs_cnt); end
    n_cmp++; if (we_cnt !== 5 || first_we !== 2) begin n_bad++; $display("FAIL wr_we got %0d from %0d want 5 from 2", we_cnt, first_we); end
    n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL wr_bus_stable got %0d bad cycles want 0", unstable); end
    n_cmp++; if (dma_cnt !== 1 || done_at !== 7) begin n_bad++; $display("FAIL wr_dma_done got x%0d at %0d want x1 at 7", dma_cnt, done_at); end
    n_cmp++; if (cpu_cnt !== 0) begin n_bad++; $display("FAIL wr_cpu_done got %0d want 0", cpu_cnt); end
    n_cmp++; if (busy7 !== 1'b1 || busy8 !== 1'b0) begin n_bad++; $display("FAIL wr_busy got %b%b want 10", busy7, busy8); end
  endtask

  task automatic test_back_to_back();
    int order[4];
    int at[4];
    int ndone = 0, both = 0;
    for (int k = 0; k < 4; k++) begin order[k] = -1; at[k] = 0; end
    reset = 1'b1; tick(); reset = 1'b0;
    cpu_rd_wr = 1'b1; cpu_addr = 16'h0030;
    dma_rd_wr = 1'b0; dma_addr = 16'h0040; dma_wdata = 16'hAAAA;
    mem_ready = 1'b1; mem_rdata = 16'h1111;
    cpu_req = 1'b1; dma_req = 1'b1;
    for (int i = 1; i <= 30 && ndone < 4; i++) begin
      tick();
      if (cpu_done && dma_done) both++;
      if (cpu_done) begin order[ndone] = 0; at[ndone] = i; ndone++; end
      else if (dma_done) begin order[ndone] = 1; at[ndone] = i; ndone++; end
      if (ndone == 4) begin cpu_req = 1'b0; dma_req = 1'b0; end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    n_cmp++; if (ndone !== 4) begin n_bad++; $display("FAIL tie_done_count got %0d want 4 within 30 cycles", ndone); end
    n_cmp++; if (order[0] !== 0 || order[1] !== 1 || order[2] !== 0 || order[3] !== 1)
      begin n_bad++; $display("FAIL tie_order got %0d%0d%0d%0d want 0101 (0=cpu 1=dma)", order[0], order[1], order[2], order[3]); end
    n_cmp++; if (at[0] !== 4 || at[3] - at[0] !== 15) begin n_bad++; $display("FAIL tie_timing got first %0d span %0d want 4 and 15", at[0], at[3] - at[0]); end
    n_cmp++; if (both !== 0) begin n_bad++; $display("FAIL tie_double_done got %0d want 0", both); end
    tick(); tick();
    n_cmp++; if (bus_busy !== 1'b0) begin n_bad++; $display("FAIL tie_end_busy got %b want 0", bus_busy); end
  endtask

  task automatic test_early_ready();
    int done_cnt = 0, done_at = 0;
    cpu_rd_wr = 1'b1; cpu_addr = 16'h0050; mem_ready = 1'b0; mem_rdata = 16'hDEAD;
    cpu_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (cpu_done) begin done_cnt++; if (done_at == 0) done_at = i; cpu_req = 1'b0; end
      if (i == 1) mem_ready = 1'b1;
      if (i == 3) mem_ready = 1'b0;
      if (i == 4) begin mem_ready = 1'b1; mem_rdata = 16'h5A5A; end
      if (i == 5) mem_ready = 1'b0;
    end
    n_cmp++; if (done_at !== 5 || done_cnt !== 1) begin n_bad++; $display("FAIL early_ready_done got at %0d x%0d want at 5 x1", done_at, done_cnt); end
    n_cmp++; if (cpu_rdata !== 16'h5A5A) begin n_bad++; $display("FAIL early_ready_data got %h want 5a5a", cpu_rdata); end
  endtask

  task automatic test_reset_mid();
    int cnt = 0, ccnt = 0, dcnt = 0, first = -1;
    cpu_rd_wr = 1'b1; cpu_addr = 16'h0060; mem_ready = 1'b0; mem_rdata = 16'h0F0F;
    cpu_req = 1'b1;
    tick(); tick();
    n_cmp++; if (mem_cs !== 1'b1) begin n_bad++; $display("FAIL rst_mid_pre_cs got %b want 1", mem_cs); end
    reset = 1'b1;
    tick();
    reset = 1'b0; cpu_req = 1'b0;
    n_cmp++; if (mem_cs !== 1'b0 || bus_busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_bus got cs %b busy %b want 0 0", mem_cs, bus_busy); end
    n_cmp++; if (cpu_rdata !== 16'h0) begin n_bad++; $display("FAIL rst_mid_rdata got %h want 0000", cpu_rdata); end
    for (int i = 0; i < 3; i++) begin tick(); if (cpu_done) cnt++; end
    n_cmp++; if (cnt !== 0) begin n_bad++; $display("FAIL rst_mid_no_done got %0d want 0", cnt); end
    mem_ready = 1'b1; mem_rdata = 16'h7777;
    dma_rd_wr = 1'b0; dma_addr = 16'h0080; dma_wdata = 16'h5555;
    cpu_req = 1'b1; dma_req = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (cpu_done) begin if (first < 0) first = 0; ccnt++; cpu_req = 1'b0; end
      if (dma_done) begin if (first < 0) first = 1; dcnt++; dma_req = 1'b0; end
    end
    n_cmp++; if (first !== 0) begin n_bad++; $display("FAIL rst_mid_tie got owner %0d want 0 (cpu)", first); end
    n_cmp++; if (ccnt !== 1 || dcnt !== 1) begin n_bad++; $display("FAIL rst_mid_tie_dones got %0d/%0d want 1/1", ccnt, dcnt); end
    n_cmp++; if (cpu_rdata !== 16'h7777) begin n_bad++; $display("FAIL rst_mid_tie_data got %h want 7777", cpu_rdata); end
  endtask

  task automatic test_timeout();
    int cnt = 0, done_at = 0, ecnt = 0;
    logic err_at_done = 1'b0;
    cpu_rd_wr = 1'b1; cpu_addr = 16'h0070; mem_ready = 1'b0; mem_rdata = 16'h9999;
    cpu_req = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (bus_err) ecnt++;
      if (cpu_done) begin cnt++; done_at = i; err_at_done = bus_err; cpu_req = 1'b0; end
    end
`ifdef BUS_TIMEOUT_EN
    n_cmp++; if (cnt !== 1 || done_at !== 17) begin n_bad++; $display("FAIL timeout_done got x%0d at %0d want x1 at 17", cnt, done_at); end
    n_cmp++; if (err_at_done !== 1'b1 || ecnt !== 1) begin n_bad++; $display("FAIL timeout_err got %b x%0d want 1 x1", err_at_done, ecnt); end
    n_cmp++; if (cpu_rdata !== 16'h0) begin n_bad++; $display("FAIL timeout_rdata got %h want 0000", cpu_rdata); end
`else
    n_cmp++; if (cnt !== 0) begin n_bad++; $display("FAIL hang_done got %0d want 0", cnt); end
    n_cmp++; if (ecnt !== 0) begin n_bad++; $display("FAIL hang_err got %0d want 0", ecnt); end
    n_cmp++; if (bus_busy !== 1'b1 || mem_cs !== 1'b1) begin n_bad++; $display("FAIL hang_busy got busy %b cs %b want 1 1", bus_busy, mem_cs); end
    n_cmp++; if (cpu_rdata !== 16'h7777) begin n_bad++; $display("FAIL hang_rdata got %h want 7777", cpu_rdata); end
`endif
    cpu_req = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write_wait();
    test_back_to_back();
    test_early_ready();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
